mpu_transpose_seq: RTL and testbench
====================================

# mpu_transpose_seq

Sequential, parametrised matrix transpose engine for the MPU datapath. It accepts a square DIM×DIM signed matrix on a start strobe and writes the transposed (or copied) result one row per clock into a registered output. It supports a runtime active size: elements outside the active top-left sub-matrix are forced to zero. It sits beside the other MPU operation units and shares their flat matrix bus format and start/busy/done handshake.

## Interface
- DIM, default 5: maximum matrix dimension (rows = cols = DIM), legal 2..8.
- WIDTH, default 8: signed element width in bits.
- SW, default $clog2(DIM+1): width of the size port (derived, not overridden).

- clock  input  1  rising-edge clock for all state.
- reset  input  1  synchronous, active-high reset.
- start  input  1  request strobe, sampled only while idle.
- mode  input  1  0 = transpose, 1 = copy (pass-through), captured at start.
- size  input  SW  active dimension; 0 or >DIM is treated as DIM; captured at start.
- matrix  input  WIDTH*DIM*DIM  source matrix, captured at start.
- result  output  WIDTH*DIM*DIM  registered result matrix.
- busy  output  1  high while an operation is in progress.
- done  output  1  single-cycle completion pulse.

## Operation
- Element (row r, col c) occupies bits [WIDTH*(c + DIM*r) +: WIDTH], for both matrix and result. Elements are signed two's complement. Values are moved unchanged, with no arithmetic and no width change.
- States: IDLE, RUN.
- IDLE: busy=0.
  - If start=1 at a rising edge: capture matrix into the source register, capture mode, and capture the effective size (0 or >DIM becomes DIM).
  - On the same edge: set row counter=0 and go to RUN.
  - start=0 leaves state unchanged.
- RUN: busy=1. At each edge, for the current row r and every column c:
  - If r<size and c<size: result[r][c] = src[c][r] when mode=0, or src[r][c] when mode=1.
  - Otherwise: result[r][c] = 0.
- Row counter increments each RUN edge. All DIM rows are always written, regardless of size.
- The edge that writes row DIM-1 sets done=1 and returns to IDLE.
- start while busy=1 is ignored, with no queuing. Changes to matrix, mode or size after capture have no effect on the running operation.
- The result register holds its value between operations. Rows of a new operation overwrite it progressively from row 0.
- reset=1 at an edge, in any state:
  - State becomes IDLE and the row counter becomes 0.
  - busy=0, done=0, result=0, source register=0.
  - reset takes priority over start.

## Timing
- Reset values: result=0, busy=0, done=0.
- Let start be sampled at edge k.
  - busy is high from after edge k through edge k+DIM.
  - Row r is written at edge k+1+r.
  - done is high for exactly one cycle, following edge k+DIM. busy is low in that same cycle.
- Latency from start to done is DIM cycles. Throughput is one matrix per DIM cycles.
- Back-to-back operation: start asserted in the done cycle is accepted, so the next operation begins with no idle gap.
- Reset mid-RUN aborts the operation: no done pulse, and result is cleared to 0.

## Test plan
- Full transpose, DIM=5, WIDTH=8, mode=0, size=5, matrix rows {1..5},{6..10},…,{21..25} -> done 5 cycles after start; result rows {1,6,11,16,21},{2,7,12,17,22},…,{5,10,15,20,25}.
- Signed values and copy mode: mode=1, elements include -128, -1 and 127 -> result bit-identical to matrix; transposing the same matrix with mode=0 preserves signs (for example, -128 moves from (0,4) to (4,0)).
- Active size: size=3, mode=0, same 1..25 matrix -> rows {1,6,11,0,0},{2,7,12,0,0},{3,8,13,0,0}, with rows 3 and 4 all zero. size=0 -> identical to size=5.
- Handshake: pulse start again during RUN with a different matrix -> ignored, result reflects only the first matrix. Assert start in the done cycle -> second result appears 5 cycles later; busy stays high with no gap.
- Reset mid-operation: reset after row 2 has been written -> next cycle result=0, busy=0, and no done pulse. A subsequent start completes normally.
- Parameter sweep: DIM=2 and DIM=8 with WIDTH=16 against a reference model, 100 random matrices/modes/sizes each -> exact match; done latency equals DIM.

Source files
------------

// File: rtl/mpu_transpose_seq_if.sv
// Flat matrix bus and start/busy/done handshake shared by the MPU operation units.
// master drives the request side, slave is the operation unit.
interface mpu_transpose_seq_if #(
  parameter int DIM   = 5,
  parameter int WIDTH = 8,
  parameter int SW    = $clog2(DIM + 1)
);
  // start is sampled only while busy=0; busy covers the whole run; done is a
  // one-cycle pulse in the first idle cycle, in which a new start is accepted.
  logic                       start;
  logic                       mode;
  logic [SW-1:0]              size;
  logic [WIDTH*DIM*DIM-1:0]   matrix;
  logic [WIDTH*DIM*DIM-1:0]   result;
  logic                       busy;
  logic                       done;

  modport master (
    output start, mode, size, matrix,
    input  result, busy, done
  );

  modport slave (
    input  start, mode, size, matrix,
    output result, busy, done
  );
endinterface

// File: rtl/mpu_transpose_seq.sv
// Sequential DIMxDIM transpose/copy engine: captures a matrix on start and
// writes one masked result row per clock into a registered output.
module mpu_transpose_seq #(
  parameter int DIM   = 5,
  parameter int WIDTH = 8,
  parameter int SW    = $clog2(DIM + 1)
) (
  input  logic               clock,
  input  logic               reset,
  mpu_transpose_seq_if.slave bus,
  output logic               state_dbg
);
  localparam int RW   = (DIM > 1) ? $clog2(DIM) : 1;
  localparam int MW   = WIDTH * DIM * DIM;
  localparam int ROWW = WIDTH * DIM;

  typedef enum logic {IDLE = 1'b0, RUN = 1'b1} state_t;

  state_t          state, state_nx;
  logic [RW-1:0]   row;
  logic [MW-1:0]   src_q;
  logic [MW-1:0]   result_q;
  logic            mode_q;
  logic [SW-1:0]   size_q;
  logic [SW-1:0]   size_eff;
  logic            done_q;
  logic            load;
  logic            step;
  logic            last;
  logic [ROWW-1:0] row_data;

  // A size of zero or one beyond DIM selects the full matrix.
  assign size_eff = (bus.size == '0 || int'(bus.size) > DIM) ? SW'(DIM) : bus.size;
  assign last     = (row == RW'(DIM - 1));

  always_comb begin
    state_nx = state;
    load     = 1'b0;
    step     = 1'b0;
    case (state)
      IDLE: begin
        if (bus.start) begin
          load     = 1'b1;
          state_nx = RUN;
        end
      end
      RUN: begin
        step = 1'b1;
        if (last) state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  // Current output row: columns outside the active sub-matrix stay zero.
  always_comb begin
    row_data = '0;
    for (int c = 0; c < DIM; c++) begin
      if (int'(row) < int'(size_q) && c < int'(size_q)) begin
        if (mode_q)
          row_data[WIDTH*c +: WIDTH] = src_q[WIDTH*(c + DIM*int'(row)) +: WIDTH];
        else
          row_data[WIDTH*c +: WIDTH] = src_q[WIDTH*(int'(row) + DIM*c) +: WIDTH];
      end
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state    <= IDLE;
      row      <= '0;
      src_q    <= '0;
      mode_q   <= 1'b0;
      size_q   <= '0;
      result_q <= '0;
      done_q   <= 1'b0;
    end else begin
      state  <= state_nx;
      done_q <= step && last;
      if (load) begin
        src_q  <= bus.matrix;
        mode_q <= bus.mode;
        size_q <= size_eff;
        row    <= '0;
      end else if (step) begin
        result_q[ROWW*int'(row) +: ROWW] <= row_data;
        row <= last ? '0 : row + RW'(1);
      end
    end
  end

  assign bus.result = result_q;
  assign bus.busy   = (state == RUN);
  assign bus.done   = done_q;
  assign state_dbg  = state;
endmodule

// File: tb/tb_mpu_transpose_seq.sv
// Directed bench for mpu_transpose_seq (DIM=5/WIDTH=8) plus a random sweep of
// DIM=2 and DIM=8 instances with WIDTH=16 against a reference model.
module tb_mpu_transpose_seq;
  logic clock = 1'b0;
  logic reset = 1'b1;
  logic st5, st2, st8;

  int n_vec = 0;
  int n_err = 0;

  mpu_transpose_seq_if #(.DIM(5), .WIDTH(8))  bus5 ();
  mpu_transpose_seq_if #(.DIM(2), .WIDTH(16)) bus2 ();
  mpu_transpose_seq_if #(.DIM(8), .WIDTH(16)) bus8 ();

  mpu_transpose_seq #(.DIM(5), .WIDTH(8)) dut5 (
    .clock(clock), .reset(reset), .bus(bus5), .state_dbg(st5));
  mpu_transpose_seq #(.DIM(2), .WIDTH(16)) dut2 (
    .clock(clock), .reset(reset), .bus(bus2), .state_dbg(st2));
  mpu_transpose_seq #(.DIM(8), .WIDTH(16)) dut8 (
    .clock(clock), .reset(reset), .bus(bus8), .state_dbg(st8));

  // clock / reset
  always #5 clock = ~clock;

  // Hand-written element tables, row-major (index = 5*r + c).
  int seq_e[25] = '{ 1,  2,  3,  4,  5,
                     6,  7,  8,  9, 10,
                    11, 12, 13, 14, 15,
                    16, 17, 18, 19, 20,
                    21, 22, 23, 24, 25};
  int seq_t[25] = '{ 1,  6, 11, 16, 21,
                     2,  7, 12, 17, 22,
                     3,  8, 13, 18, 23,
                     4,  9, 14, 19, 24,
                     5, 10, 15, 20, 25};
  int seq_s3[25] = '{1,  6, 11,  0,  0,
                     2,  7, 12,  0,  0,
                     3,  8, 13,  0,  0,
                     0,  0,  0,  0,  0,
                     0,  0,  0,  0,  0};
  int sgn_e[25] = '{ 1,   2,  3,  4, -128,
                    -1, 127,  0,  5,    6,
                    11,  12, 13, 14,   15,
                    16,  17, 18, 19,   20,
                    21,  22, 23, 24,   25};
  int sgn_t[25] = '{   1, -1, 11, 16, 21,
                       2, 127, 12, 17, 22,
                       3,  0, 13, 18, 23,
                       4,  5, 14, 19, 24,
                    -128,  6, 15, 20, 25};

  function automatic logic [199:0] pack5(input int e[25]);
    logic [199:0] p;
    p = '0;
    for (int i = 0; i < 25; i++) p[8*i +: 8] = 8'(e[i]);
    return p;
  endfunction

  function automatic logic [1023:0] ref_model(input logic [1023:0] m, input int dim,
                                              input int w, input int md, input int sz);
    logic [1023:0] res;
    int s;
    int src;
    res = '0;
    s = (sz == 0 || sz > dim) ? dim : sz;
    for (int r = 0; r < dim; r++) begin
      for (int c = 0; c < dim; c++) begin
        if (r < s && c < s) begin
          src = (md != 0) ? (c + dim*r) : (r + dim*c);
          for (int b = 0; b < w; b++) res[w*(c + dim*r) + b] = m[w*src + b];
        end
      end
    end
    return res;
  endfunction

  task automatic check(input string tag, input logic [1023:0] got, input logic [1023:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // driver tasks
  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic start5(input logic [199:0] m, input logic md, input logic [2:0] sz);
    bus5.matrix = m;
    bus5.mode   = md;
    bus5.size   = sz;
    bus5.start  = 1'b1;
    tick();
    bus5.start  = 1'b0;
  endtask

  task automatic wait_done(input int which, output int lat);
    logic d;
    lat = 0;
    do begin
      tick();
      lat++;
      case (which)
        2:       d = bus2.done;
        8:       d = bus8.done;
        default: d = bus5.done;
      endcase
    end while (d !== 1'b1 && lat < 20);
  endtask

  task automatic sweep2();
    logic [1023:0] m;
    logic [1023:0] exp;
    int md, sz, lat;
    for (int n = 0; n < 100; n++) begin
      m = '0;
      for (int i = 0; i < 2; i++) m[32*i +: 32] = $urandom();
      md = $urandom_range(0, 1);
      sz = $urandom_range(0, 3);
      exp = ref_model(m, 2, 16, md, sz);
      bus2.matrix = m[63:0];
      bus2.mode   = md[0];
      bus2.size   = 2'(sz);
      bus2.start  = 1'b1;
      tick();
      bus2.start  = 1'b0;
      wait_done(2, lat);
      check("d2_latency", lat, 2);
      check("d2_result", bus2.result, exp);
    end
  endtask

  task automatic sweep8();
    logic [1023:0] m;
    logic [1023:0] exp;
    int md, sz, lat;
    for (int n = 0; n < 100; n++) begin
      for (int i = 0; i < 32; i++) m[32*i +: 32] = $urandom();
      md = $urandom_range(0, 1);
      sz = $urandom_range(0, 15);
      exp = ref_model(m, 8, 16, md, sz);
      bus8.matrix = m;
      bus8.mode   = md[0];
      bus8.size   = 4'(sz);
      bus8.start  = 1'b1;
      tick();
      bus8.start  = 1'b0;
      wait_done(8, lat);
      check("d8_latency", lat, 8);
      check("d8_result", bus8.result, exp);
    end
  endtask

  initial begin
    logic [199:0] seq_m, seq_tr, seq_3, sgn_m, sgn_tr, expv;
    int lat, seen;

    seq_m  = pack5(seq_e);
    seq_tr = pack5(seq_t);
    seq_3  = pack5(seq_s3);
    sgn_m  = pack5(sgn_e);
    sgn_tr = pack5(sgn_t);

    bus5.start = 1'b0; bus5.mode = 1'b0; bus5.size = '0; bus5.matrix = '0;
    bus2.start = 1'b0; bus2.mode = 1'b0; bus2.size = '0; bus2.matrix = '0;
    bus8.start = 1'b0; bus8.mode = 1'b0; bus8.size = '0; bus8.matrix = '0;

    reset = 1'b1;
    tick();
    tick();
    check("rst_result", bus5.result, '0);
    check("rst_busy", bus5.busy, 1'b0);
    check("rst_done", bus5.done, 1'b0);
    reset = 1'b0;
    tick();

    // Full transpose of the 1..25 matrix.
    start5(seq_m, 1'b0, 3'd5);
    check("t_busy_after_start", bus5.busy, 1'b1);
    wait_done(5, lat);
    check("t_latency", lat, 5);
    check("t_busy_in_done", bus5.busy, 1'b0);
    check("t_result", bus5.result, seq_tr);
    tick();
    check("t_done_one_cycle", bus5.done, 1'b0);

    // Signed values: copy then transpose.
    start5(sgn_m, 1'b1, 3'd5);
    wait_done(5, lat);
    check("copy_result", bus5.result, sgn_m);
    start5(sgn_m, 1'b0, 3'd5);
    wait_done(5, lat);
    check("sgn_t_result", bus5.result, sgn_tr);
    check("sgn_t_elem40", bus5.result[8*20 +: 8], 8'h80);

    // Active size 3, then size 0 and 7 meaning full.
    start5(seq_m, 1'b0, 3'd3);
    wait_done(5, lat);
    check("size3_result", bus5.result, seq_3);
    start5(seq_m, 1'b0, 3'd0);
    wait_done(5, lat);
    check("size0_result", bus5.result, seq_tr);
    start5(sgn_m, 1'b1, 3'd7);
    wait_done(5, lat);
    check("size7_result", bus5.result, sgn_m);

    // Start during RUN is ignored.
    start5(seq_m, 1'b0, 3'd5);
    tick();
    bus5.matrix = sgn_m;
    bus5.mode   = 1'b1;
    bus5.start  = 1'b1;
    tick();
    bus5.start  = 1'b0;
    wait_done(5, lat);
    check("ign_latency", lat + 2, 5);
    check("ign_result", bus5.result, seq_tr);

    // Back-to-back: start in the done cycle.
    start5(sgn_m, 1'b1, 3'd5);
    check("b2b_busy", bus5.busy, 1'b1);
    check("b2b_done_low", bus5.done, 1'b0);
    wait_done(5, lat);
    check("b2b_latency", lat, 5);
    check("b2b_result", bus5.result, sgn_m);

    // Progressive overwrite then reset after row 2.
    start5(seq_m, 1'b0, 3'd5);
    tick();
    tick();
    tick();
    expv = {sgn_m[199:120], seq_tr[119:0]};
    check("partial_rows", bus5.result, expv);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check("abort_result", bus5.result, '0);
    check("abort_busy", bus5.busy, 1'b0);
    seen = 0;
    for (int i = 0; i < 7; i++) begin
      if (bus5.done === 1'b1) seen++;
      tick();
    end
    check("abort_no_done", seen, 0);
    start5(seq_m, 1'b0, 3'd5);
    wait_done(5, lat);
    check("post_rst_latency", lat, 5);
    check("post_rst_result", bus5.result, seq_tr);

    sweep2();
    sweep8();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
